mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle RV32M multiply/divide controller that reuses the shared 32-bit ALU instead of owning a separate adder.
- Sequences the ALU through operand negation, 32 shift-add or restore-subtract iterations, and result sign fix-up.
- Sits beside the execute stage. Core raises start for an M-extension instruction, stalls while busy, and takes result on done.

Parameters:
XLEN, 32, datapath width; only 32 is supported (iteration count fixed at 32).

Ports:
clk  input  1  system clock
reset  input  1  reset
start  input  1  request; accepted only when busy=0
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  input  32  operand a (dividend / multiplicand)
rs2  input  32  operand b (divisor / multiplier)
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result valid
result  output  32  result, held until next accepted start
alu_a  output  32  ALU operand a
alu_b  output  32  ALU operand b
alu_control  output  4  ALU op: ADD 0000, SUB 0001, XOR 0101
alu_out  input  32  ALU result
alu_carry  input  1  ADD: carry-out; SUB: borrow (1 when a<b unsigned)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state IDLE; busy=0, done=0, result=0, all internal registers cleared.
- Reset mid-operation aborts to IDLE with no done.
- ALU outputs are always driven. Idle/unused cycles present ADD 0,0.
- States: IDLE -> NEG_A -> NEG_B -> ITER (32 cycles, 5-bit counter) -> FIX -> IDLE.
- busy=1 from the cycle after accept through FIX inclusive.
- done pulses in the cycle after FIX, together with the new result.
- Fixed latency: start accepted at cycle 0, done at cycle 36.
- start while busy=1 is ignored. start in the same cycle as done is accepted.
- Fast path, decided in IDLE from raw operands, skips all states. busy stays 0 and done/result appear at cycle 1:
  - DIV/DIVU with rs2=0: result 0xFFFFFFFF.
  - REM/REMU with rs2=0: result = rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- Signedness:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - MUL is computed unsigned (low word is identical).
- NEG_A: if a is signed and a[31]=1, drive SUB(0,a); else ADD(a,0). Latch alu_out as a magnitude. Same for NEG_B with b.
- Result sign flags, latched at accept:
  - MULH/DIV: a[31]^b[31] (each bit counted only if that operand is signed).
  - MULHSU: a[31].
  - REM: a[31].
  - Otherwise 0.
- Multiply ITER, with hi=0 and lo=b_mag initially:
  - Drive ADD(hi, lo[0] ? a_mag : 0).
  - Update hi <= {alu_carry, alu_out[31:1]} and lo <= {alu_out[0], lo[31:1]}.
- Divide ITER, with rem=0 and quo=a_mag initially:
  - Let sh = {rem[30:0], quo[31]} and top = rem[31]. Drive SUB(sh, b_mag).
  - If top | ~alu_carry: rem <= alu_out, quo <= {quo[30:0],1}.
  - Else: rem <= sh, quo <= {quo[30:0],0}.
- FIX selects x: MUL lo; MULH* hi; DIV* quo; REM* rem.
  - Sign flag 0: ADD(x,0).
  - Sign flag 1, non-MULH ops: SUB(0,x).
  - Sign flag 1, MULH/MULHSU: SUB(0,hi) if lo==0, else XOR(hi,0xFFFFFFFF).
  - result <= alu_out at the end of FIX.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> done exactly at cycle 36, result 0xFFFFFFEB; busy high during cycles 1-35.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF (exercises the lo!=0 XOR fix path).
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Fast path: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done at cycle 1 and busy never asserted; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1.
- start pulsed at cycles 5 and 20 during an operation -> ignored; single done at cycle 36 with the first op's result; back-to-back start in the done cycle accepted.
- Assert reset at cycle 10 of a DIV -> next cycle busy=0, done=0, result=0, ALU inputs ADD 0,0; no done pulse ever appears for the aborted op.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide sequencer driving a shared ALU
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_carry
);
    typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, ITER, FIX} state_t;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] XOR = 4'b0101;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    state_t state, next_state;
    logic [2:0] op_r;
    logic [XLEN-1:0] a_r, b_r, hi, lo, sh, x, fast_val;
    logic [4:0] cnt;
    logic sa, sb, neg, fast, in_neg, in_sa, in_sb, is_mulh, fix_xor;
    assign in_sa = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6) & rs1[XLEN-1];
    assign in_sb = (op == 3'd1 || op == 3'd4 || op == 3'd6) & rs2[XLEN-1];
    assign in_neg = (op == 3'd1 || op == 3'd4) ? rs1[XLEN-1] ^ rs2[XLEN-1]
                  : (op == 3'd2 || op == 3'd6) & rs1[XLEN-1];
    assign fast = op[2] & (rs2 == '0 || (!op[0] && rs1 == MIN && rs2 == '1));
    assign fast_val = (rs2 == '0) ? (op[1] ? rs1 : '1) : (op[1] ? '0 : MIN);
    assign sh = {hi[XLEN-2:0], lo[XLEN-1]};
    assign is_mulh = op_r == 3'd1 || op_r == 3'd2;
    assign x = (op_r == 3'd0 || op_r[2:1] == 2'b10) ? lo : hi;
    assign fix_xor = neg & is_mulh & (lo != '0);
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end
    // next-state logic; fast-path requests never leave IDLE
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = (start && !fast) ? NEG_A : IDLE;
            NEG_A:   next_state = NEG_B;
            NEG_B:   next_state = ITER;
            ITER:    next_state = (cnt == 5'd31) ? FIX : ITER;
            default: next_state = IDLE;
        endcase
    end
    // ALU operand selection per state; idle presents ADD 0,0
    always_comb begin
        busy = state != IDLE;
        alu_a = '0;
        alu_b = '0;
        alu_control = ADD;
        case (state)
            NEG_A: begin
                alu_a = sa ? '0 : a_r;
                alu_b = sa ? a_r : '0;
                alu_control = sa ? SUB : ADD;
            end
            NEG_B: begin
                alu_a = sb ? '0 : b_r;
                alu_b = sb ? b_r : '0;
                alu_control = sb ? SUB : ADD;
            end
            ITER: begin
                alu_a = op_r[2] ? sh : hi;
                alu_b = op_r[2] ? b_r : (lo[0] ? a_r : '0);
                alu_control = op_r[2] ? SUB : ADD;
            end
            FIX: begin
                alu_a = neg ? (fix_xor ? hi : '0) : x;
                alu_b = neg ? (fix_xor ? '1 : x) : '0;
                alu_control = neg ? (fix_xor ? XOR : SUB) : ADD;
            end
            default: ;
        endcase
    end
    // datapath: operand capture, magnitudes, shift-add / restoring-divide iterations, result
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r <= '0;
            a_r <= '0;
            b_r <= '0;
            hi <= '0;
            lo <= '0;
            cnt <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            neg <= 1'b0;
            done <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_r <= op;
                    a_r <= rs1;
                    b_r <= rs2;
                    sa <= in_sa;
                    sb <= in_sb;
                    neg <= in_neg;
                    if (fast) begin
                        done <= 1'b1;
                        result <= fast_val;
                    end
                end
                NEG_A: a_r <= alu_out;
                NEG_B: begin
                    b_r <= alu_out;
                    hi <= '0;
                    lo <= op_r[2] ? a_r : alu_out;
                    cnt <= '0;
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    if (!op_r[2]) begin
                        hi <= {alu_carry, alu_out[XLEN-1:1]};
                        lo <= {alu_out[0], lo[XLEN-1:1]};
                    end else if (hi[XLEN-1] | ~alu_carry) begin
                        hi <= alu_out;
                        lo <= {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi <= sh;
                        lo <= {lo[XLEN-2:0], 1'b0};
                    end
                end
                FIX: begin
                    result <= alu_out;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed checks of the multiply/divide sequencer with a behavioural ALU
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [2:0] op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic busy, done;
    logic [31:0] result, alu_a, alu_b, alu_out;
    logic [3:0] alu_control;
    logic alu_carry;
    int checks = 0;
    int failures = 0;

    mdu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .busy(busy), .done(done), .result(result), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .alu_out(alu_out), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    // shared ALU: ADD with carry-out, SUB with borrow, XOR
    always_comb begin
        alu_out = '0;
        alu_carry = 1'b0;
        if (alu_control == 4'b0001) begin
            alu_out = alu_a - alu_b;
            alu_carry = alu_a < alu_b;
        end else if (alu_control == 4'b0101) begin
            alu_out = alu_a ^ alu_b;
        end else begin
            {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bcnt);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        lat = 0; bcnt = 0; res = '0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            tick();
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                res = result;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
        checks++; if ({alu_control, alu_a, alu_b} !== 68'h0) begin failures++;
            $display("FAIL reset_alu got ctrl=%b a=%h b=%h exp ADD 0,0", alu_control, alu_a, alu_b); end
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, bc;
        issue(3'd0, 32'd7, 32'hFFFFFFFD, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
        checks++; if (lat !== 36) begin failures++; $display("FAIL mul_latency got=%0d exp=36", lat); end
        checks++; if (bc !== 35) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=35", bc); end
    endtask

    task automatic test_mulh_div();
        logic [2:0] ops[7] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as[7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs[7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ex[7] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [31:0] r; int lat, bc;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], r, lat, bc);
            checks++; if (r !== ex[i] || lat !== 36) begin failures++;
                $display("FAIL op%0d_result got=%h lat=%0d exp=%h lat=36", ops[i], r, lat, ex[i]); end
        end
    endtask

    task automatic test_fast_path();
        logic [2:0] ops[4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as[4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs[4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] r; int lat, bc;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], r, lat, bc);
            checks++; if (r !== ex[i] || lat !== 1 || bc !== 0) begin failures++;
                $display("FAIL fast%0d got=%h lat=%0d busy=%0d exp=%h lat=1 busy=0", i, r, lat, bc, ex[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0, first = 0;
        logic [31:0] r = '0;
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            start = (c == 5 || c == 20);
            if (start) begin op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; end
            if (done) begin
                ndone++;
                if (first == 0) begin first = c; r = result; end
            end
        end
        checks++; if (ndone !== 1 || first !== 36) begin failures++;
            $display("FAIL ignore_done got count=%0d at=%0d exp count=1 at=36", ndone, first); end
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL ignore_result got=%h exp=0000000e", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat, bc;
        issue(3'd0, 32'd6, 32'd9, r, lat, bc);
        checks++; if (r !== 32'd54) begin failures++; $display("FAIL b2b_first got=%h exp=00000036", r); end
        issue(3'd7, 32'd100, 32'd7, r, lat, bc);
        checks++; if (r !== 32'd2 || lat !== 36) begin failures++;
            $display("FAIL b2b_second got=%h lat=%0d exp=00000002 lat=36", r, lat); end
        tick();
        checks++; if (done !== 1'b0 || result !== 32'd2) begin failures++;
            $display("FAIL b2b_pulse got done=%b result=%h exp done=0 result=00000002", done, result); end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        op = 3'd4; rs1 = 32'hFFFFFFF9; rs2 = 32'd2; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin failures++;
            $display("FAIL abort_state got busy=%b done=%b result=%h exp 0 0 00000000", busy, done, result); end
        checks++; if ({alu_control, alu_a, alu_b} !== 68'h0) begin failures++;
            $display("FAIL abort_alu got ctrl=%b a=%h b=%h exp ADD 0,0", alu_control, alu_a, alu_b); end
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh_div();
        test_fast_path();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
